// File: rtl/multi_edge_detector_if.sv
// Bundles the raw inputs, per-channel controls and detector outputs of multi_edge_detector.
interface multi_edge_detector_if #(
    parameter int unsigned CH    = 4,
    parameter int unsigned CNT_W = 8
);
    logic [CH-1:0]       sig_in;
    logic [2*CH-1:0]     mode;
    logic [CH-1:0]       clr;
    logic [CH-1:0]       lvl;
    logic [CH-1:0]       pe;
    logic [CH-1:0]       ne;
    logic [CH-1:0]       ev;
    logic [CH-1:0]       sticky;
    logic [CH*CNT_W-1:0] ev_cnt;
    logic                irq;

    // Driver side: supplies inputs and controls, observes results.
    modport master (
        output sig_in, mode, clr,
        input  lvl, pe, ne, ev, sticky, ev_cnt, irq
    );

    // Detector side.
    modport slave (
        input  sig_in, mode, clr,
        output lvl, pe, ne, ev, sticky, ev_cnt, irq
    );
endinterface

// File: rtl/multi_edge_detector.sv
// CH-channel synchronised, glitch-filtered edge detector with mode-qualified
// events, sticky flags, saturating event counters and an aggregate interrupt.
module multi_edge_detector #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT        = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_edge_detector_if.slave bus
);
    localparam int unsigned       FCNT_W   = $clog2(FILT) + 1;
    localparam logic [FCNT_W-1:0] FLIM     = FCNT_W'(FILT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q [CH];
    logic [SYNC_STAGES-1:0] sync_d [CH];
    logic [FCNT_W-1:0]      fcnt_q [CH];
    logic [FCNT_W-1:0]      fcnt_d [CH];
    logic [CNT_W-1:0]       cnt_q  [CH];
    logic [CNT_W-1:0]       cnt_d  [CH];

    logic [CH-1:0] lvl_q, lvl_d;
    logic [CH-1:0] pe_q, pe_d;
    logic [CH-1:0] ne_q, ne_d;
    logic [CH-1:0] ev_q, ev_d;
    logic [CH-1:0] sticky_q, sticky_d;
    logic          irq_q, irq_d;
    logic [CH*CNT_W-1:0] ev_cnt_flat;

    // Next-state for synchroniser, filter, edge pulses, events, sticky flags and counters.
    always_comb begin
        irq_d = |sticky_q;
        for (int i = 0; i < CH; i++) begin
            sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], bus.sig_in[i]};
            fcnt_d[i]   = fcnt_q[i];
            lvl_d[i]    = lvl_q[i];
            pe_d[i]     = 1'b0;
            ne_d[i]     = 1'b0;
            sticky_d[i] = sticky_q[i];
            cnt_d[i]    = cnt_q[i];

            // A level change is accepted only after FILT consecutive differing samples.
            if (sync_q[i][SYNC_STAGES-1] == lvl_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] < FLIM) begin
                fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
            end else begin
                lvl_d[i]  = sync_q[i][SYNC_STAGES-1];
                fcnt_d[i] = '0;
                pe_d[i]   = sync_q[i][SYNC_STAGES-1];
                ne_d[i]   = ~sync_q[i][SYNC_STAGES-1];
            end

            ev_d[i] = (bus.mode[2*i+1] & ne_d[i]) | (bus.mode[2*i] & pe_d[i]);

            // A clear coinciding with a visible event restarts the count at one.
            if (bus.clr[i] && ev_q[i]) begin
                sticky_d[i] = 1'b1;
                cnt_d[i]    = CNT_W'(1);
            end else if (bus.clr[i]) begin
                sticky_d[i] = 1'b0;
                cnt_d[i]    = '0;
            end else if (ev_q[i]) begin
                sticky_d[i] = 1'b1;
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= '0;
                fcnt_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            lvl_q    <= '0;
            pe_q     <= '0;
            ne_q     <= '0;
            ev_q     <= '0;
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= sync_d[i];
                fcnt_q[i] <= fcnt_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            lvl_q    <= lvl_d;
            pe_q     <= pe_d;
            ne_q     <= ne_d;
            ev_q     <= ev_d;
            sticky_q <= sticky_d;
            irq_q    <= irq_d;
        end
    end

    // Pack per-channel counters onto the flat output bus.
    always_comb begin
        ev_cnt_flat = '0;
        for (int i = 0; i < CH; i++) begin
            ev_cnt_flat[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign bus.lvl    = lvl_q;
    assign bus.pe     = pe_q;
    assign bus.ne     = ne_q;
    assign bus.ev     = ev_q;
    assign bus.sticky = sticky_q;
    assign bus.ev_cnt = ev_cnt_flat;
    assign bus.irq    = irq_q;
endmodule
